mem_arbiter: RTL
================

# mem_arbiter

Shares the single byte-wide RAM port between instruction fetch, LSB loads and LSB stores. Serialises each 1/2/4-byte access into byte transactions and assembles read bytes into a word. Handshakes with the fetch unit and the load/store buffer through level requests, one-cycle grants and one-cycle done pulses. Sits between those units and the top-level memory/IO bus.

## Interface
- ADDR_WIDTH, 32, byte address width
- WORD_WIDTH, 32, data word width
- clk_in  in  1  system clock, all state on rising edge
- rst_n_in  in  1  reset, asynchronous, active-low
- rdy_in  in  1  global ready; when low, all state and outputs hold
- if_r_en_in  in  1  fetch read request, level, held until grant
- if_r_a_in  in  32  fetch address
- if_r_gr_out  out  1  fetch grant pulse
- if_r_en_out  out  1  fetch done pulse
- if_d_out  out  32  fetch data, valid with done
- lsb_r_en_in  in  1  load request, level
- lsb_r_offset_in  in  2  bytes-1 (0, 1 or 3)
- lsb_r_a_in  in  32  load address
- lsb_r_gr_out  out  1  load grant pulse
- lsb_r_en_out  out  1  load done pulse
- lsb_d_out  out  32  load data, zero-extended, valid with done
- lsb_w_en_in  in  1  store request, level
- lsb_w_offset_in  in  2  bytes-1
- lsb_w_a_in  in  32  store address
- lsb_d_in  in  32  store data, low bytes used
- lsb_w_gr_out  out  1  store grant pulse
- lsb_w_en_out  out  1  store done pulse
- mem_din_in  in  8  RAM read byte
- mem_dout_out  out  8  RAM write byte
- mem_a_out  out  32  RAM address
- mem_wr_out  out  1  1 = write
- io_buffer_full_in  in  1  IO write buffer full
- clear_branch_in  in  1  misprediction flush

## Operation
- States: IDLE, READ, WRITE. Registered byte counter cnt (3 bits), latched owner (IF/LR/LW), offset, address, write data.
- IDLE: sample requests; priority store > load > fetch. Winner: grant pulse, latch fields, cnt<=0, enter READ (fetch: offset=3) or WRITE. None: mem_a=0, mem_wr=0, mem_dout=0.
- READ: mem_a=addr+cnt for cnt=0..offset. Byte cnt-1 arrives on mem_din one cycle after its address; stored into lane cnt-1 of the word. When byte `offset` captured: done pulse to owner with word, upper unused bytes 0, return to IDLE.
- WRITE: mem_wr=1, mem_a=addr+cnt, mem_dout=data byte cnt, cnt++ each cycle; after byte `offset` written: done pulse, return to IDLE.
- IO stall: in WRITE with addr[17:16]==2'b11 and io_buffer_full_in=1, drive mem_wr=0, hold cnt; resume when it deasserts.
- Address arithmetic wraps modulo 2^32.
- clear_branch_in: if owner is IF or LR, abort at that edge: IDLE, no done, mem_wr=0. Ongoing store (committed) is not aborted. Grant pulses in the same edge are suppressed for IF/LR.
- Requests arriving while busy are ignored (requester keeps en high); en sampled only in IDLE.

## Timing
- Reset (async, rst_n_in=0): state IDLE, cnt=0, all grant/done outputs 0, mem_a=0, mem_wr=0, mem_dout=0, if_d_out=0, lsb_d_out=0.
- All outputs registered. Request seen at edge t -> grant high in cycle t..t+1, first byte address on mem_a same cycle.
- Read of N bytes: done pulse N+1 cycles after grant cycle; fetch word = 5 cycles grant-to-done.
- Write of N bytes (no stall): done N cycles after grant cycle.
- Done cycle is in IDLE; next request accepted at the following edge (one-cycle gap minimum).
- Requester deasserts en the cycle after observing grant; arbiter never re-grants a busy-ignored duplicate because en is only sampled in IDLE.
- Grant and done are exactly one cycle wide; never both to different owners in one cycle.

## Structure
- Shared package: state encoding, owner encoding, IO region constant (addr[17:16]==2'b11), offset codes (byte 0, half 1, word 3).
- No sub-module; byte-lane insert/select as local functions.

## Test plan
- Fetch 0x00000004, RAM bytes 11 22 33 44 -> if_r_gr_out at cycle 1, mem_a 4,5,6,7, if_d_out=0x44332211 with done 5 cycles after grant.
- LSB LH at 0x10, bytes AB CD -> lsb_d_out=0x0000CDAB, done 3 cycles after grant; fetch requested simultaneously granted only after done.
- Simultaneous store SW 0x20 data 0xDEADBEEF, load and fetch -> store first: mem_wr=1, bytes EF BE AD DE at 0x20..0x23; then load, then fetch.
- SB to 0x30000 with io_buffer_full_in high 3 cycles -> mem_wr held 0 for 3 cycles, then writes; done delayed exactly 3 cycles.
- clear_branch_in mid-fetch (cnt=2) -> no if_r_en_out, IDLE next cycle; same pulse during SW -> store completes with done.
- rst_n_in low mid-write -> outputs zero immediately (asynchronous), IDLE after release.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// Shared encodings for the memory arbiter: FSM states, owners,
// access-size codes and the IO address region.
package mem_arbiter_pkg;

    // FSM state encoding
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_READ  = 2'd1;
    localparam logic [1:0] ST_WRITE = 2'd2;

    // Owner of the transaction in flight
    localparam logic [1:0] OWN_NONE = 2'd0;
    localparam logic [1:0] OWN_IF   = 2'd1;
    localparam logic [1:0] OWN_LR   = 2'd2;
    localparam logic [1:0] OWN_LW   = 2'd3;

    // Access size codes (bytes - 1)
    localparam logic [1:0] OFF_BYTE = 2'd0;
    localparam logic [1:0] OFF_HALF = 2'd1;
    localparam logic [1:0] OFF_WORD = 2'd3;

    // addr[17:16] value that selects the IO region
    localparam logic [1:0] IO_REGION = 2'b11;

endpackage

// File: rtl/mem_arbiter_if.sv
// Request/grant/done handshakes of fetch and LSB plus the byte-wide RAM port.
// slave: the arbiter side; master: the requesters and memory side.
interface mem_arbiter_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int WORD_WIDTH = 32
);
    logic                  if_r_en_in;
    logic [ADDR_WIDTH-1:0] if_r_a_in;
    logic                  if_r_gr_out;
    logic                  if_r_en_out;
    logic [WORD_WIDTH-1:0] if_d_out;

    logic                  lsb_r_en_in;
    logic [1:0]            lsb_r_offset_in;
    logic [ADDR_WIDTH-1:0] lsb_r_a_in;
    logic                  lsb_r_gr_out;
    logic                  lsb_r_en_out;
    logic [WORD_WIDTH-1:0] lsb_d_out;

    logic                  lsb_w_en_in;
    logic [1:0]            lsb_w_offset_in;
    logic [ADDR_WIDTH-1:0] lsb_w_a_in;
    logic [WORD_WIDTH-1:0] lsb_d_in;
    logic                  lsb_w_gr_out;
    logic                  lsb_w_en_out;

    logic [7:0]            mem_din_in;
    logic [7:0]            mem_dout_out;
    logic [ADDR_WIDTH-1:0] mem_a_out;
    logic                  mem_wr_out;

    logic                  io_buffer_full_in;
    logic                  clear_branch_in;

    modport slave (
        input  if_r_en_in, if_r_a_in,
        output if_r_gr_out, if_r_en_out, if_d_out,
        input  lsb_r_en_in, lsb_r_offset_in, lsb_r_a_in,
        output lsb_r_gr_out, lsb_r_en_out, lsb_d_out,
        input  lsb_w_en_in, lsb_w_offset_in, lsb_w_a_in, lsb_d_in,
        output lsb_w_gr_out, lsb_w_en_out,
        input  mem_din_in,
        output mem_dout_out, mem_a_out, mem_wr_out,
        input  io_buffer_full_in, clear_branch_in
    );

    modport master (
        output if_r_en_in, if_r_a_in,
        input  if_r_gr_out, if_r_en_out, if_d_out,
        output lsb_r_en_in, lsb_r_offset_in, lsb_r_a_in,
        input  lsb_r_gr_out, lsb_r_en_out, lsb_d_out,
        output lsb_w_en_in, lsb_w_offset_in, lsb_w_a_in, lsb_d_in,
        input  lsb_w_gr_out, lsb_w_en_out,
        output mem_din_in,
        input  mem_dout_out, mem_a_out, mem_wr_out,
        output io_buffer_full_in, clear_branch_in
    );
endinterface

// File: rtl/mem_arbiter.sv
// Byte-wide RAM port arbiter: store > load > fetch, serialises 1/2/4-byte
// accesses into byte transactions and assembles read bytes into a word.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int WORD_WIDTH = 32
) (
    input  logic          clk_in,
    input  logic          rst_n_in,
    input  logic          rdy_in,
    mem_arbiter_if.slave  bus
);

    logic [1:0]            state;
    logic [1:0]            owner;
    logic [1:0]            offset;
    logic [2:0]            cnt;
    logic [ADDR_WIDTH-1:0] addr;
    logic [WORD_WIDTH-1:0] wdata;
    logic [WORD_WIDTH-1:0] rword;

    logic                  if_gr_q, if_done_q, lr_gr_q, lr_done_q, lw_gr_q, lw_done_q;
    logic [WORD_WIDTH-1:0] if_d_q, lsb_d_q;
    logic [ADDR_WIDTH-1:0] mem_a_q;
    logic [7:0]            mem_dout_q;
    logic                  mem_wr_q;

    logic [2:0]            cnt_p1;
    logic [1:0]            rd_lane;
    logic                  io_stall;
    logic                  abort_read;

    function automatic logic [WORD_WIDTH-1:0] lane_insert(
        input logic [WORD_WIDTH-1:0] w,
        input logic [1:0]            lane,
        input logic [7:0]            b
    );
        logic [WORD_WIDTH-1:0] r;
        r = w;
        r[{lane, 3'b000} +: 8] = b;
        return r;
    endfunction

    function automatic logic [7:0] lane_select(
        input logic [WORD_WIDTH-1:0] w,
        input logic [1:0]            lane
    );
        return w[{lane, 3'b000} +: 8];
    endfunction

    // Helper terms: next byte index, lane of the byte on mem_din, IO stall and flush abort
    always_comb begin
        cnt_p1     = cnt + 3'd1;
        rd_lane    = cnt[1:0] - 2'd1;
        io_stall   = (addr[17:16] == IO_REGION) && bus.io_buffer_full_in;
        abort_read = bus.clear_branch_in && ((owner == OWN_IF) || (owner == OWN_LR));
    end

    // Arbitration FSM, byte sequencing and registered outputs
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state      <= ST_IDLE;
            owner      <= OWN_NONE;
            offset     <= OFF_BYTE;
            cnt        <= '0;
            addr       <= '0;
            wdata      <= '0;
            rword      <= '0;
            if_gr_q    <= 1'b0;
            if_done_q  <= 1'b0;
            lr_gr_q    <= 1'b0;
            lr_done_q  <= 1'b0;
            lw_gr_q    <= 1'b0;
            lw_done_q  <= 1'b0;
            if_d_q     <= '0;
            lsb_d_q    <= '0;
            mem_a_q    <= '0;
            mem_dout_q <= '0;
            mem_wr_q   <= 1'b0;
        end else if (rdy_in) begin
            if_gr_q   <= 1'b0;
            if_done_q <= 1'b0;
            lr_gr_q   <= 1'b0;
            lr_done_q <= 1'b0;
            lw_gr_q   <= 1'b0;
            lw_done_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    cnt   <= '0;
                    rword <= '0;
                    if (bus.lsb_w_en_in) begin
                        owner      <= OWN_LW;
                        offset     <= bus.lsb_w_offset_in;
                        addr       <= bus.lsb_w_a_in;
                        wdata      <= bus.lsb_d_in;
                        state      <= ST_WRITE;
                        lw_gr_q    <= 1'b1;
                        mem_a_q    <= bus.lsb_w_a_in;
                        mem_dout_q <= lane_select(bus.lsb_d_in, 2'd0);
                        // first byte may already be stalled by a full IO buffer
                        mem_wr_q   <= !((bus.lsb_w_a_in[17:16] == IO_REGION) && bus.io_buffer_full_in);
                    end else if (bus.lsb_r_en_in && !bus.clear_branch_in) begin
                        owner      <= OWN_LR;
                        offset     <= bus.lsb_r_offset_in;
                        addr       <= bus.lsb_r_a_in;
                        state      <= ST_READ;
                        lr_gr_q    <= 1'b1;
                        mem_a_q    <= bus.lsb_r_a_in;
                        mem_dout_q <= '0;
                        mem_wr_q   <= 1'b0;
                    end else if (bus.if_r_en_in && !bus.clear_branch_in) begin
                        owner      <= OWN_IF;
                        offset     <= OFF_WORD;
                        addr       <= bus.if_r_a_in;
                        state      <= ST_READ;
                        if_gr_q    <= 1'b1;
                        mem_a_q    <= bus.if_r_a_in;
                        mem_dout_q <= '0;
                        mem_wr_q   <= 1'b0;
                    end else begin
                        owner      <= OWN_NONE;
                        mem_a_q    <= '0;
                        mem_dout_q <= '0;
                        mem_wr_q   <= 1'b0;
                    end
                end

                ST_READ: begin
                    if (abort_read) begin
                        state    <= ST_IDLE;
                        mem_a_q  <= '0;
                        mem_wr_q <= 1'b0;
                    end else if (cnt == ({1'b0, offset} + 3'd1)) begin
                        // last byte is on mem_din now: publish the word directly
                        state   <= ST_IDLE;
                        mem_a_q <= '0;
                        if (owner == OWN_IF) begin
                            if_done_q <= 1'b1;
                            if_d_q    <= lane_insert(rword, rd_lane, bus.mem_din_in);
                        end else begin
                            lr_done_q <= 1'b1;
                            lsb_d_q   <= lane_insert(rword, rd_lane, bus.mem_din_in);
                        end
                    end else begin
                        if (cnt != 3'd0) begin
                            rword <= lane_insert(rword, rd_lane, bus.mem_din_in);
                        end
                        cnt <= cnt_p1;
                        if (cnt < {1'b0, offset}) begin
                            mem_a_q <= addr + ADDR_WIDTH'(cnt_p1);
                        end
                    end
                end

                ST_WRITE: begin
                    // mem_wr low means byte cnt is still pending behind an IO stall
                    if (!mem_wr_q) begin
                        mem_wr_q <= !io_stall;
                    end else if (cnt == {1'b0, offset}) begin
                        state      <= ST_IDLE;
                        lw_done_q  <= 1'b1;
                        mem_a_q    <= '0;
                        mem_dout_q <= '0;
                        mem_wr_q   <= 1'b0;
                    end else begin
                        cnt        <= cnt_p1;
                        mem_a_q    <= addr + ADDR_WIDTH'(cnt_p1);
                        mem_dout_q <= lane_select(wdata, cnt_p1[1:0]);
                        mem_wr_q   <= !io_stall;
                    end
                end

                default: begin
                    state    <= ST_IDLE;
                    mem_a_q  <= '0;
                    mem_wr_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.if_r_gr_out  = if_gr_q;
    assign bus.if_r_en_out  = if_done_q;
    assign bus.if_d_out     = if_d_q;
    assign bus.lsb_r_gr_out = lr_gr_q;
    assign bus.lsb_r_en_out = lr_done_q;
    assign bus.lsb_d_out    = lsb_d_q;
    assign bus.lsb_w_gr_out = lw_gr_q;
    assign bus.lsb_w_en_out = lw_done_q;
    assign bus.mem_a_out    = mem_a_q;
    assign bus.mem_dout_out = mem_dout_q;
    assign bus.mem_wr_out   = mem_wr_q;

endmodule
